// File: rtl/fifo_flex.sv
`default_nettype none
// ============================================================================
// Module   : fifo_flex
// Brief    : Single-clock FIFO with show-ahead/normal read modes, optional
//            output register, synchronous flush and sticky error flags.
// Revision : 1.0
// ============================================================================
module fifo_flex #(
   parameter int DWIDTH             = 32,
   parameter int AWIDTH             = 4,
   parameter int SHOWAHEAD          = 1,
   parameter int ALMOST_FULL_VALUE  = 12,
   parameter int ALMOST_EMPTY_VALUE = 4,
   parameter int REGISTER_OUTPUT    = 0
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic [DWIDTH-1:0] data_i,
   input  logic              wrreq_i,
   input  logic              rdreq_i,
   input  logic              flush_i,
   input  logic              clr_err_i,
   output logic [DWIDTH-1:0] q_o,
   output logic              empty_o,
   output logic              full_o,
   output logic [AWIDTH:0]   usedw_o,
   output logic              almost_full_o,
   output logic              almost_empty_o,
   output logic              overflow_o,
   output logic              underflow_o
);

   localparam int              C_DEPTH = 2**AWIDTH;
   localparam logic [AWIDTH:0] C_FULL  = {1'b1, {AWIDTH{1'b0}}};
   localparam logic [AWIDTH:0] C_ONE   = (AWIDTH+1)'(1);
   localparam logic [AWIDTH:0] C_AF    = (AWIDTH+1)'(ALMOST_FULL_VALUE);
   localparam logic [AWIDTH:0] C_AE    = (AWIDTH+1)'(ALMOST_EMPTY_VALUE);

   if (DWIDTH < 1) begin : g_bad_dwidth
      $error("fifo_flex: DWIDTH must be >= 1");
   end
   if (ALMOST_FULL_VALUE < 0 || ALMOST_FULL_VALUE > C_DEPTH) begin : g_bad_af
      $error("fifo_flex: ALMOST_FULL_VALUE out of range");
   end
   if (ALMOST_EMPTY_VALUE < 0 || ALMOST_EMPTY_VALUE > C_DEPTH) begin : g_bad_ae
      $error("fifo_flex: ALMOST_EMPTY_VALUE out of range");
   end
   if (SHOWAHEAD != 0 && SHOWAHEAD != 1) begin : g_bad_sa
      $error("fifo_flex: SHOWAHEAD must be 0 or 1");
   end
   if (REGISTER_OUTPUT != 0 && REGISTER_OUTPUT != 1) begin : g_bad_ro
      $error("fifo_flex: REGISTER_OUTPUT must be 0 or 1");
   end

   logic [DWIDTH-1:0] r_mem [C_DEPTH];
   logic [AWIDTH-1:0] r_wptr;
   logic [AWIDTH-1:0] r_rptr;
   logic [AWIDTH-1:0] w_rptr_nxt;
   logic [AWIDTH:0]   r_usedw;
   logic [AWIDTH:0]   w_usedw_nxt;
   logic              r_ovf;
   logic              r_udf;
   logic              w_full;
   logic              w_empty;
   logic              w_wr;
   logic              w_rd;

   assign w_full  = (r_usedw == C_FULL);
   assign w_empty = (r_usedw == '0);
   // A read at full frees no slot for the same-cycle write.
   assign w_wr    = wrreq_i && !w_full  && !flush_i;
   assign w_rd    = rdreq_i && !w_empty && !flush_i;

   always_comb begin
      w_usedw_nxt = r_usedw;
      w_rptr_nxt  = r_rptr;
      if (flush_i) begin
         w_usedw_nxt = '0;
         w_rptr_nxt  = '0;
      end else begin
         if (w_wr && !w_rd) begin
            w_usedw_nxt = r_usedw + 1'b1;
         end else if (!w_wr && w_rd) begin
            w_usedw_nxt = r_usedw - 1'b1;
         end
         if (w_rd) begin
            w_rptr_nxt = r_rptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_usedw <= '0;
         r_rptr  <= '0;
         r_wptr  <= '0;
      end else begin
         r_usedw <= w_usedw_nxt;
         r_rptr  <= w_rptr_nxt;
         if (flush_i) begin
            r_wptr <= '0;
         end else if (w_wr) begin
            r_wptr <= r_wptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_wr) begin
         r_mem[r_wptr] <= data_i;
      end
   end

   // Set has priority over clear; flush cycles never flag.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         r_ovf <= (wrreq_i && w_full  && !flush_i) || (r_ovf && !clr_err_i);
         r_udf <= (rdreq_i && w_empty && !flush_i) || (r_udf && !clr_err_i);
      end
   end

   assign empty_o        = w_empty;
   assign full_o         = w_full;
   assign usedw_o        = r_usedw;
   assign almost_full_o  = (r_usedw >= C_AF);
   assign almost_empty_o = (r_usedw <  C_AE);
   assign overflow_o     = r_ovf;
   assign underflow_o    = r_udf;

   if (SHOWAHEAD != 0) begin : g_showahead
      if (REGISTER_OUTPUT != 0) begin : g_reg
         logic [DWIDTH-1:0] r_q;
         // Preload the word that will be at the head after this edge.
         always_ff @(posedge clk_i) begin
            if (srst_i) begin
               r_q <= '0;
            end else if (w_usedw_nxt != '0) begin
               if (w_wr && (w_usedw_nxt == C_ONE)) begin
                  r_q <= data_i;
               end else begin
                  r_q <= r_mem[w_rptr_nxt];
               end
            end
         end
         assign q_o = r_q;
      end else begin : g_comb
         assign q_o = w_empty ? '0 : r_mem[r_rptr];
      end
   end else begin : g_normal
      if (REGISTER_OUTPUT != 0) begin : g_reg
         logic [DWIDTH-1:0] r_q;
         logic [DWIDTH-1:0] r_q1;
         logic              r_v1;
         always_ff @(posedge clk_i) begin
            if (srst_i) begin
               r_q  <= '0;
               r_q1 <= '0;
               r_v1 <= 1'b0;
            end else begin
               r_v1 <= w_rd;
               if (w_rd) begin
                  r_q1 <= r_mem[r_rptr];
               end
               if (r_v1) begin
                  r_q <= r_q1;
               end
            end
         end
         assign q_o = r_q;
      end else begin : g_comb
         logic [DWIDTH-1:0] r_q;
         always_ff @(posedge clk_i) begin
            if (srst_i) begin
               r_q <= '0;
            end else if (w_rd) begin
               r_q <= r_mem[r_rptr];
            end
         end
         assign q_o = r_q;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_flex
// Brief    : Scoreboard bench driving all four mode combinations of fifo_flex.
// Revision : 1.0
// ============================================================================
module tb_fifo_flex;

   logic        clk = 1'b0;
   logic        srst = 1'b0;
   logic [31:0] data = '0;
   logic        wrreq = 1'b0;
   logic        rdreq = 1'b0;
   logic        flush = 1'b0;
   logic        clr = 1'b0;

   logic [31:0] q      [4];
   logic        empty  [4];
   logic        full   [4];
   logic [4:0]  usedw  [4];
   logic        afull  [4];
   logic        aempty [4];
   logic        ovf    [4];
   logic        udf    [4];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Instance index = SHOWAHEAD*2 + REGISTER_OUTPUT.
   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      fifo_flex #(
         .DWIDTH(32), .AWIDTH(4), .SHOWAHEAD(gi / 2),
         .ALMOST_FULL_VALUE(12), .ALMOST_EMPTY_VALUE(4),
         .REGISTER_OUTPUT(gi % 2)
      ) u_dut (
         .clk_i(clk), .srst_i(srst), .data_i(data), .wrreq_i(wrreq),
         .rdreq_i(rdreq), .flush_i(flush), .clr_err_i(clr),
         .q_o(q[gi]), .empty_o(empty[gi]), .full_o(full[gi]),
         .usedw_o(usedw[gi]), .almost_full_o(afull[gi]),
         .almost_empty_o(aempty[gi]), .overflow_o(ovf[gi]),
         .underflow_o(udf[gi])
      );
   end

   task automatic chk(input string nm, input int inst, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, inst, $time, act, exp);
      end
   endtask

   // Reference model: a queue of stored words plus sticky flags.
   typedef struct { int due; logic [31:0] d; } sb_t;
   logic [31:0] mq [$];
   sb_t         sb0 [$];
   sb_t         sb1 [$];
   bit          m_ovf = 0;
   bit          m_udf = 0;
   bit          started = 0;
   int          cyc = 0;

   always @(posedge clk) begin
      bit          m_full;
      bit          m_empty;
      logic [31:0] d;
      cyc++;
      if (srst) begin
         mq.delete();
         sb0.delete();
         sb1.delete();
         sb0.push_back('{cyc, 32'h0});
         sb1.push_back('{cyc, 32'h0});
         m_ovf = 0;
         m_udf = 0;
         started = 1;
      end else begin
         m_full  = (mq.size() == 16);
         m_empty = (mq.size() == 0);
         if (clr) begin
            m_ovf = 0;
            m_udf = 0;
         end
         if (!flush) begin
            if (wrreq && m_full)  m_ovf = 1;
            if (rdreq && m_empty) m_udf = 1;
         end
         if (flush) begin
            mq.delete();
         end else begin
            if (rdreq && !m_empty) begin
               d = mq.pop_front();
               sb0.push_back('{cyc, d});
               sb1.push_back('{cyc + 1, d});
            end
            if (wrreq && !m_full) mq.push_back(data);
         end
      end
   end

   // Monitor: compares every instance against the model mid-cycle.
   logic [31:0] exp0 = '0;
   logic [31:0] exp1 = '0;
   always @(negedge clk) begin
      if (started) begin
         while (sb0.size() > 0 && sb0[0].due <= cyc) begin
            exp0 = sb0[0].d;
            void'(sb0.pop_front());
         end
         while (sb1.size() > 0 && sb1[0].due <= cyc) begin
            exp1 = sb1[0].d;
            void'(sb1.pop_front());
         end
         for (int i = 0; i < 4; i++) begin
            chk("usedw",  i, 32'(usedw[i]),  32'(mq.size()));
            chk("empty",  i, 32'(empty[i]),  32'(mq.size() == 0));
            chk("full",   i, 32'(full[i]),   32'(mq.size() == 16));
            chk("afull",  i, 32'(afull[i]),  32'(mq.size() >= 12));
            chk("aempty", i, 32'(aempty[i]), 32'(mq.size() < 4));
            chk("ovf",    i, 32'(ovf[i]),    32'(m_ovf));
            chk("udf",    i, 32'(udf[i]),    32'(m_udf));
         end
         chk("q_norm", 0, q[0], exp0);
         chk("q_norm_reg", 1, q[1], exp1);
         if (mq.size() > 0) begin
            chk("q_sa", 2, q[2], mq[0]);
            chk("q_sa_reg", 3, q[3], mq[0]);
         end
      end
   end

   task automatic step(input logic wr, input logic rd, input logic fl,
                       input logic cl, input logic rs, input logic [31:0] d);
      wrreq = wr;
      rdreq = rd;
      flush = fl;
      clr   = cl;
      srst  = rs;
      data  = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int pw [5] = '{70, 30, 50, 90, 100};
      int pr [5] = '{30, 70, 50, 90, 100};

      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) chk("rst_usedw", i, 32'(usedw[i]), 32'd0);
      chk("rst_q", 0, q[0], 32'd0);

      for (int i = 0; i < 16; i++) begin
         step(1, 0, 0, 0, 0, 32'(i));
         if (i == 10) chk("af_before", 0, 32'(afull[0]), 32'd0);
         if (i == 11) chk("af_at12", 0, 32'(afull[0]), 32'd1);
      end
      chk("fill_usedw", 0, 32'(usedw[0]), 32'd16);
      chk("fill_full", 0, 32'(full[0]), 32'd1);

      step(1, 1, 0, 0, 0, 32'hDEAD_BEEF);
      chk("wr_at_full_usedw", 0, 32'(usedw[0]), 32'd15);
      chk("wr_at_full_ovf", 0, 32'(ovf[0]), 32'd1);
      step(0, 0, 0, 1, 0, 0);
      chk("clr_ovf", 0, 32'(ovf[0]), 32'd0);

      step(0, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 32'hA5);
      chk("sa_empty", 2, 32'(empty[2]), 32'd0);
      chk("sa_q", 2, q[2], 32'hA5);
      chk("sa_q_reg", 3, q[3], 32'hA5);
      step(0, 1, 0, 0, 0, 0);
      chk("sa_ack_empty", 2, 32'(empty[2]), 32'd1);
      chk("sa_ack_udf", 2, 32'(udf[2]), 32'd0);

      step(1, 0, 0, 0, 0, 32'h11);
      step(1, 0, 0, 0, 0, 32'h22);
      step(1, 0, 0, 0, 0, 32'h33);
      step(0, 1, 0, 0, 0, 0);
      chk("norm_q1", 0, q[0], 32'h11);
      step(0, 1, 0, 0, 0, 0);
      chk("nreg_q1", 1, q[1], 32'h11);
      step(0, 1, 0, 0, 0, 0);
      chk("nreg_q2", 1, q[1], 32'h22);
      step(0, 0, 0, 0, 0, 0);
      chk("nreg_q3", 1, q[1], 32'h33);

      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, $urandom);
      for (int i = 0; i < 40; i++) step(1, 1, 0, 0, 0, $urandom);
      chk("stream_usedw", 0, 32'(usedw[0]), 32'd5);

      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, $urandom);
      step(1, 0, 1, 0, 0, $urandom);
      chk("flush_usedw", 0, 32'(usedw[0]), 32'd0);
      chk("flush_empty", 0, 32'(empty[0]), 32'd1);
      step(1, 0, 0, 0, 0, 32'h0000_BEEF);
      step(0, 1, 0, 0, 0, 0);
      chk("post_flush_q", 0, q[0], 32'h0000_BEEF);
      step(0, 1, 0, 0, 0, 0);
      chk("post_flush_udf", 0, 32'(udf[0]), 32'd1);

      for (int ph = 0; ph < 5; ph++) begin
         for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < pw[ph], $urandom_range(0, 99) < pr[ph],
                 $urandom_range(0, 99) < 1, $urandom_range(0, 99) < 2,
                 $urandom_range(0, 999) < 3, $urandom);
         end
      end
      step(0, 0, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_flex.md
# fifo_flex

Second-generation single-clock FIFO: parametrised width and depth, with selectable show-ahead or normal read mode, an optional registered output, and synchronous flush. Adds sticky overflow/underflow error flags with a clear input. It is the drop-in buffer between streaming stages wherever the first-generation FIFO was used. Its accept rules at full and empty are defined exactly, so upstream/downstream handshakes can rely on them.

## Interface
- DWIDTH, 32, data word width (>=1)
- AWIDTH, 4, address width; depth = 2**AWIDTH words
- SHOWAHEAD, 1, 1: head word presented on q_o while !empty_o, rdreq_i acts as ack; 0: normal mode, rdreq_i requests a word
- ALMOST_FULL_VALUE, 12, almost_full threshold, legal range 0..2**AWIDTH
- ALMOST_EMPTY_VALUE, 4, almost_empty threshold, legal range 0..2**AWIDTH
- REGISTER_OUTPUT, 0, 1: normal mode gets one extra q_o pipeline stage; show-ahead q_o is a flop
- clk_i  in  1  clock; all logic on rising edge
- srst_i  in  1  synchronous active-high reset
- data_i  in  DWIDTH  write data
- wrreq_i  in  1  write request
- rdreq_i  in  1  read request (normal) / read acknowledge (show-ahead)
- flush_i  in  1  synchronous flush, discards all contents
- clr_err_i  in  1  clears overflow_o/underflow_o
- q_o  out  DWIDTH  read data
- empty_o  out  1  no words stored
- full_o  out  1  2**AWIDTH words stored
- usedw_o  out  AWIDTH+1  stored word count, 0..2**AWIDTH
- almost_full_o  out  1  usedw_o >= ALMOST_FULL_VALUE
- almost_empty_o  out  1  usedw_o < ALMOST_EMPTY_VALUE
- overflow_o  out  1  sticky: a write was dropped
- underflow_o  out  1  sticky: a read was dropped

## Operation
- Reset values: usedw_o=0, empty_o=1, full_o=0, almost_full_o=(ALMOST_FULL_VALUE==0), almost_empty_o=(ALMOST_EMPTY_VALUE>0), overflow_o=0, underflow_o=0, q_o=0, pointers=0. Memory contents are not reset.
- Write accepted iff wrreq_i && !full_o && !flush_i. Read accepted iff rdreq_i && !empty_o && !flush_i.
- No write-through when full: with a read at full, the write is still dropped.
- Pointers are AWIDTH bits and wrap modulo 2**AWIDTH.
- usedw_o: +1 on write only, -1 on read only, unchanged on both or neither. It never exceeds 2**AWIDTH and never drops below 0.
- empty_o = (usedw_o==0) and full_o = (usedw_o==2**AWIDTH), both from registered state. almost flags are compares on usedw_o.
- overflow_o sets on wrreq_i && full_o; underflow_o sets on rdreq_i && empty_o.
- Error flags clear on srst_i or clr_err_i. If clr_err_i and a set condition occur in the same cycle, set wins.
- Flush: the next state is usedw_o=0, empty_o=1 and pointers=0. wrreq_i/rdreq_i in the flush cycle are ignored and do not set error flags. q_o holds its value, and error flags are unaffected.
- Show-ahead: while !empty_o, q_o equals the oldest stored word. Writing into an empty FIFO bypasses the write data to the output, so q_o is valid in the same cycle empty_o falls. q_o is don't-care while empty_o=1.
- Normal: q_o updates only on an accepted read and otherwise holds its last value.
- Assertions: ALMOST_* thresholds within their legal range; SHOWAHEAD and REGISTER_OUTPUT each in {0,1}.

## Timing
- Write accepted at edge N: usedw_o, empty_o and full_o reflect it after edge N, i.e. in cycle N+1.
- Show-ahead: after a write at edge N into an empty FIFO, q_o holds that word in cycle N+1 for both REGISTER_OUTPUT values.
- Show-ahead: ack at edge N, and the next word (or empty_o=1) appears in cycle N+1.
- Normal, REGISTER_OUTPUT=0: read accepted at edge N gives the word on q_o in cycle N+1.
- Normal, REGISTER_OUTPUT=1: read accepted at edge N gives the word on q_o in cycle N+2.
- Error flags assert in the cycle after the offending request.
- Full throughput: one write and one read per cycle sustained indefinitely, at any fill level between 1 and 2**AWIDTH-1.
- srst_i mid-operation: every output takes its reset value in the next cycle, and in-flight reads in the REGISTER_OUTPUT pipeline are discarded.

## Test plan
- Reset, then write 16 words 0..15 (AWIDTH=4) -> after the 16th write: full_o=1, usedw_o=16, almost_full_o=1 from the 12th write.
- At full, drive wrreq_i+rdreq_i -> usedw_o goes to 15, the write is dropped and overflow_o=1. clr_err_i -> overflow_o=0.
- SHOWAHEAD=1, single write 0xA5 into empty -> next cycle empty_o=0 and q_o=0xA5. Ack -> next cycle empty_o=1 and underflow_o stays 0.
- SHOWAHEAD=0, REGISTER_OUTPUT=1, write 3 words then read 3 back-to-back -> data appears 2 cycles after each read edge, in order.
- Simultaneous read/write for 40 cycles at usedw_o=5 -> usedw_o stays 5, the pointers wrap twice and data order is preserved.
- flush_i at usedw_o=9 with wrreq_i=1 -> next cycle usedw_o=0 and empty_o=1. The next write is the only word later read.
